cpu_bus_responder: RTL

Memory-side responder for the CPU's external address/data bus. It decodes each CPU access against the NES CPU memory map:
- internal 2 KB work RAM, mirrored;
- PPU register window;
- $4014 sprite-DMA trigger;
- PRG ROM port.

It returns registered read data to the CPU. It also runs the OAM DMA engine, which stalls the CPU via rdy and copies a 256-byte page to PPU register $2004.

---
 rtl/cpu_bus_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// CPU-side memory responder: decodes the NES CPU map (mirrored work RAM,
// PPU register window, $4014 sprite-DMA trigger, PRG ROM), returns read
// data one cycle after the access, and runs the OAM DMA engine that stalls
// the CPU while it copies a 256-byte page to PPU register $2004.
module cpu_bus_responder #(
  parameter int RAM_AW = 11,
  parameter int PRG_AW = 15
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic              rw,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rdy,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_data,
  output logic [2:0]        ppu_reg,
  output logic              ppu_re,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  output logic              dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RD, S_WR} state_t;

  state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;

  // Effective address and its decode
  logic [15:0]       ea;
  logic              in_ram, in_ppu, in_rom, is_trig;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;

  // Work RAM with a registered read port
  logic [7:0] mem [2**RAM_AW];
  logic [7:0] ram_q;

  // Read path: non-RAM source byte captured alongside the RAM read; rdata
  // shows the fresh capture after a read and otherwise the held value.
  logic [7:0] oth_d, oth_q;
  logic       sel_ram_q;
  logic       ld_q;
  logic [7:0] hold_q;
  logic [7:0] src_byte;

  // PPU strobe registers
  logic       ppu_re_q, ppu_re_d;
  logic       ppu_we_q, ppu_we_d;
  logic [2:0] ppu_reg_q, ppu_reg_d;
  logic [7:0] ppu_wdata_q, ppu_wdata_d;

  // Address mux and decode; the DMA engine owns the bus outside IDLE
  always_comb begin
    ea       = (state_q == S_IDLE) ? addr : {page_q, idx_q};
    in_ram   = (ea[15:13] == 3'b000);
    in_ppu   = (ea[15:13] == 3'b001);
    in_rom   = ea[15];
    is_trig  = (ea == 16'h4014);
    ram_idx  = ea[RAM_AW-1:0];
    prg_addr = ea[PRG_AW-1:0];
    if (in_rom)      oth_d = prg_data;
    else if (in_ppu) oth_d = ppu_rdata;
    else             oth_d = 8'h00;
    src_byte = sel_ram_q ? ram_q : oth_q;
    rdata    = ld_q ? src_byte : hold_q;
  end

  // DMA next-state logic plus CPU/DMA strobe and RAM-write generation
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    ram_we      = 1'b0;
    ppu_re_d    = 1'b0;
    ppu_we_d    = 1'b0;
    ppu_reg_d   = ppu_reg_q;
    ppu_wdata_d = ppu_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (!rw) begin
          if (is_trig) begin
            state_d = S_ALIGN;
            page_d  = wdata;
            idx_d   = 8'h00;
          end
          if (in_ram) ram_we = 1'b1;
          if (in_ppu) begin
            ppu_we_d    = 1'b1;
            ppu_reg_d   = ea[2:0];
            ppu_wdata_d = wdata;
          end
        end else if (in_ppu) begin
          ppu_re_d  = 1'b1;
          ppu_reg_d = ea[2:0];
        end
      end
      S_ALIGN: state_d = S_RD;
      S_RD: begin
        if (in_ppu) begin
          ppu_re_d  = 1'b1;
          ppu_reg_d = idx_q[2:0];
        end
        state_d = S_WR;
      end
      S_WR: begin
        ppu_we_d    = 1'b1;
        ppu_reg_d   = 3'd4;
        ppu_wdata_d = src_byte;
        idx_d       = idx_q + 8'd1;
        state_d     = (idx_q == 8'hFF) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Work RAM: write commits at the edge, read is registered every cycle
  always_ff @(posedge clk_ph1) begin
    if (rst && ram_we) mem[ram_idx] <= wdata;
    ram_q <= mem[ram_idx];
  end

  // State, read-path and strobe registers with synchronous active-low reset
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      oth_q       <= 8'h00;
      sel_ram_q   <= 1'b0;
      ld_q        <= 1'b0;
      hold_q      <= 8'h00;
      ppu_re_q    <= 1'b0;
      ppu_we_q    <= 1'b0;
      ppu_reg_q   <= 3'd0;
      ppu_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      oth_q       <= oth_d;
      sel_ram_q   <= in_ram;
      ld_q        <= (state_q == S_IDLE) && rw;
      hold_q      <= rdata;
      ppu_re_q    <= ppu_re_d;
      ppu_we_q    <= ppu_we_d;
      ppu_reg_q   <= ppu_reg_d;
      ppu_wdata_q <= ppu_wdata_d;
    end
  end

  assign dma_active = (state_q != S_IDLE);
  assign rdy        = (state_q == S_IDLE);
  assign ppu_re     = ppu_re_q;
  assign ppu_we     = ppu_we_q;
  assign ppu_reg    = ppu_reg_q;
  assign ppu_wdata  = ppu_wdata_q;

endmodule
